lives_tracker: RTL and testbench

- Per-player lives bookkeeping stage; sits directly upstream of the game audio block and drives its 2-bit lives input. It also feeds the display and LED logic.
- Converts an asynchronous hit signal into at most one life decrement per hit.
- After each hit it enforces a post-hit invulnerability window, then declares game over when lives reach 0.
- Restarts on a new_game request.

---
 rtl/lives_tracker.sv | 91 +++++++++
 tb/tb_lives_tracker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lives_tracker.sv
// Per-player lives bookkeeping: synchronizes a raw hit level, charges one life per rising edge, then holds off further hits.
// Latency: a hit sampled at edge E updates lives/hit_ack at E+2; all outputs registered.
// Backpressure: none; new_game overrides any hit seen in the same cycle.
module lives_tracker #(
    parameter int START_LIVES   = 3,
    parameter int INVULN_CYCLES = 50000000,
    parameter int TW            = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hit,
    input  logic       new_game,
    output logic [1:0] lives,
    output logic       game_over,
    output logic       invuln,
    output logic       hit_ack
);

    typedef enum logic [1:0] {
        ALIVE,
        INVULN,
        DEAD
    } state_t;

    state_t        state;
    logic          s1;
    logic          s2;
    logic          s3;
    logic [TW-1:0] timer;
    logic          hit_rise;

    assign hit_rise = s2 & ~s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ALIVE;
            lives     <= 2'(START_LIVES);
            game_over <= 1'b0;
            invuln    <= 1'b0;
            hit_ack   <= 1'b0;
            timer     <= '0;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
        end else begin
            s1      <= hit;
            s2      <= s1;
            s3      <= s2;
            hit_ack <= 1'b0;
            if (new_game) begin
                state     <= ALIVE;
                lives     <= 2'(START_LIVES);
                game_over <= 1'b0;
                invuln    <= 1'b0;
                timer     <= '0;
            end else begin
                case (state)
                    ALIVE: begin
                        if (hit_rise && lives > 2'd1) begin
                            lives   <= lives - 2'd1;
                            hit_ack <= 1'b1;
                            timer   <= TW'(INVULN_CYCLES - 1);
                            invuln  <= 1'b1;
                            state   <= INVULN;
                        end else if (hit_rise && lives == 2'd1) begin
                            lives     <= 2'd0;
                            hit_ack   <= 1'b1;
                            game_over <= 1'b1;
                            state     <= DEAD;
                        end
                    end
                    INVULN: begin
                        // Timer holds at zero on exit; only a new hit reloads it.
                        if (timer == '0) begin
                            invuln <= 1'b0;
                            state  <= ALIVE;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    DEAD: begin
                        lives     <= 2'd0;
                        game_over <= 1'b1;
                    end
                    default: state <= ALIVE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lives_tracker.sv
// Self-checking bench for lives_tracker with a cycle-level behavioural model (INVULN_CYCLES = 8).
module tb_lives_tracker;

    localparam int N  = 8;
    localparam int SL = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hit = 1'b0;
    logic       new_game = 1'b0;
    logic [1:0] lives;
    logic       game_over;
    logic       invuln;
    logic       hit_ack;

    always #5 clk = ~clk;

    lives_tracker #(
        .START_LIVES  (SL),
        .INVULN_CYCLES(N),
        .TW           (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hit      (hit),
        .new_game (new_game),
        .lives    (lives),
        .game_over(game_over),
        .invuln   (invuln),
        .hit_ack  (hit_ack)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    // Reference model: lives count, the cycle the last window opened, and the sampled hit history.
    int m_lives;
    bit m_ack;
    bit m_inv_valid;
    int m_inv_start;
    bit hist[$];

    function automatic logic [4:0] m_expect();
        logic inv;
        inv = m_inv_valid && ((cyc - m_inv_start) < N);
        return {2'(m_lives), (m_lives == 0), inv, m_ack};
    endfunction

    function automatic logic [4:0] observed();
        return {lives, game_over, invuln, hit_ack};
    endfunction

    task automatic model_reset();
        m_lives     = SL;
        m_ack       = 1'b0;
        m_inv_valid = 1'b0;
        m_inv_start = 0;
        hist.delete();
        hist.push_back(1'b0);
        hist.push_back(1'b0);
        hist.push_back(1'b0);
    endtask

    // Drive inputs at the falling edge, advance one rising edge, update model, return at next falling edge.
    task automatic tick(input bit h, input bit ng);
        bit rise;
        bit in_window;
        hit      = h;
        new_game = ng;
        @(posedge clk);
        cyc++;
        // An edge on hit is acted on two clocks after it is first sampled.
        rise      = hist[hist.size()-2] && !hist[hist.size()-3];
        in_window = m_inv_valid && ((cyc - m_inv_start) <= N);
        hist.push_back(h);
        if (hist.size() > 4) void'(hist.pop_front());
        m_ack = 1'b0;
        if (ng) begin
            m_lives     = SL;
            m_inv_valid = 1'b0;
        end else if (m_lives > 0 && rise && !in_window) begin
            m_lives--;
            m_ack = 1'b1;
            if (m_lives > 0) begin
                m_inv_valid = 1'b1;
                m_inv_start = cyc;
            end
        end
        @(negedge clk);
        new_game = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        hit   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (observed() !== 5'b11_0_0_0)
            $display("FAIL reset_state: got %b, want %b", observed(), 5'b11_0_0_0);
        else passed++;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (observed() !== m_expect())
                $display("FAIL reset_idle cyc%0d: got %b, want %b", i, observed(), m_expect());
            else passed++;
        end
    endtask

    task automatic test_held_hit();
        int inv_cnt = 0;
        int ack_cnt = 0;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, 1'b0);
            inv_cnt += int'(invuln);
            ack_cnt += int'(hit_ack);
            checks++;
            if (observed() !== m_expect())
                $display("FAIL held_hit cyc%0d: got %b, want %b", i, observed(), m_expect());
            else passed++;
            if (i == 2) begin
                checks++;
                if ({lives, hit_ack, invuln} !== 4'b10_1_1)
                    $display("FAIL held_hit_first_update: got %b, want %b", {lives, hit_ack, invuln}, 4'b1011);
                else passed++;
            end
        end
        checks++;
        if (inv_cnt != N) $display("FAIL held_hit_invuln_len: got %0d, want %0d", inv_cnt, N);
        else passed++;
        checks++;
        if (ack_cnt != 1 || lives !== 2'd2)
            $display("FAIL held_hit_single: acks %0d lives %0d, want 1 and 2", ack_cnt, lives);
        else passed++;
        tick(1'b0, 1'b0);
    endtask

    task automatic test_invuln_ignore();
        int ack_cnt = 0;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            tick((i == 0) || (i == 3) || (i >= 14 && i <= 15), 1'b0);
            if (i >= 3 && i <= 12) ack_cnt += int'(hit_ack);
            checks++;
            if (observed() !== m_expect())
                $display("FAIL invuln_ignore cyc%0d: got %b, want %b", i, observed(), m_expect());
            else passed++;
            if (i == 12) begin
                checks++;
                if (lives !== 2'd2 || ack_cnt != 0)
                    $display("FAIL invuln_window_hit: lives %0d acks %0d, want 2 and 0", lives, ack_cnt);
                else passed++;
            end
        end
        checks++;
        if (lives !== 2'd1) $display("FAIL invuln_after_hit: got lives %0d, want 1", lives);
        else passed++;
    endtask

    task automatic test_to_dead();
        do_reset();
        for (int i = 0; i < 80; i++) begin
            tick((i % 20) < 2, 1'b0);
            checks++;
            if (observed() !== m_expect())
                $display("FAIL to_dead cyc%0d: got %b, want %b", i, observed(), m_expect());
            else passed++;
            if (i == 42) begin
                checks++;
                if ({lives, game_over, invuln, hit_ack} !== 5'b00_1_0_1)
                    $display("FAIL dead_entry: got %b, want %b", observed(), 5'b00101);
                else passed++;
            end
        end
        checks++;
        if ({lives, game_over, invuln} !== 4'b00_1_0)
            $display("FAIL dead_hold: got %b, want %b", {lives, game_over, invuln}, 4'b0010);
        else passed++;
    endtask

    task automatic test_new_game_priority();
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        checks++;
        if ({lives, game_over, hit_ack} !== 4'b11_0_0)
            $display("FAIL new_game_priority: got %b, want %b", {lives, game_over, hit_ack}, 4'b1100);
        else passed++;
        for (int i = 0; i < 12; i++) begin
            tick(i >= 4, 1'b0);
            checks++;
            if (observed() !== m_expect())
                $display("FAIL new_game_rehit cyc%0d: got %b, want %b", i, observed(), m_expect());
            else passed++;
        end
        checks++;
        if (lives !== 2'd2) $display("FAIL new_game_next_hit: got lives %0d, want 2", lives);
        else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 7; i++) tick(i == 0, 1'b0);
        checks++;
        if ({lives, invuln} !== 3'b10_1)
            $display("FAIL async_pre: got %b, want %b", {lives, invuln}, 3'b101);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (observed() !== 5'b11_0_0_0)
            $display("FAIL async_reset_immediate: got %b, want %b", observed(), 5'b11000);
        else passed++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick(i == 12, 1'b0);
            checks++;
            if (observed() !== m_expect())
                $display("FAIL async_after cyc%0d: got %b, want %b", i, observed(), m_expect());
            else passed++;
        end
    endtask

    task automatic test_random();
        bit h = 1'b0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5) == 0) h = ~h;
            tick(h, $urandom_range(39) == 0);
            checks++;
            if (observed() !== m_expect())
                $display("FAIL random cyc%0d: got %b, want %b", i, observed(), m_expect());
            else passed++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_held_hit();
        test_invuln_ignore();
        test_to_dead();
        test_new_game_priority();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
